// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : addsub_arbiter_if                                     |
// | Purpose  : Request/operand/grant and result-channel bundle for   |
// |            the two-requester shared add/sub unit.                |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface addsub_arbiter_if;
   // Requester side
   logic        req0;
   logic        req1;
   logic [15:0] a0;
   logic [15:0] b0;
   logic [15:0] a1;
   logic [15:0] b1;
   logic        sub0;
   logic        sub1;
   logic        gnt0;
   logic        gnt1;
   // Result channel
   logic        res_valid;
   logic        res_ready;
   logic        res_id;
   logic [15:0] result;
   logic        cout;
   logic        ovf;

   // Arbiter view
   modport slave (
      input  req0, req1, a0, b0, a1, b1, sub0, sub1, res_ready,
      output gnt0, gnt1, res_valid, res_id, result, cout, ovf
   );

   // Requester / consumer view
   modport master (
      output req0, req1, a0, b0, a1, b1, sub0, sub1, res_ready,
      input  gnt0, gnt1, res_valid, res_id, result, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : adder_subtractor_16_bit / addsub_arbiter              |
// | Purpose  : One shared 16-bit adder/subtractor time-multiplexed   |
// |            between two requesters with round-robin arbitration  |
// |            and a valid/ready result channel.                     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+

// Combinational 16-bit add/sub with carry-out and signed overflow.
module adder_subtractor_16_bit (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        sub_i,
   output logic [15:0] sum_o,
   output logic        cout_o,
   output logic        ovf_o
);
   logic [15:0] w_b_eff;
   logic [16:0] w_sum;

   // Subtraction is a + ~b + 1; the carry-in is the op bit itself.
   assign w_b_eff = b_i ^ {16{sub_i}};
   assign w_sum   = {1'b0, a_i} + {1'b0, w_b_eff} + {16'd0, sub_i};
   assign sum_o   = w_sum[15:0];
   assign cout_o  = w_sum[16];
   // Overflow: like-signed operands produced an opposite-signed result.
   assign ovf_o   = (a_i[15] == w_b_eff[15]) && (w_sum[15] != a_i[15]);
endmodule

module addsub_arbiter (
   input  logic                  clk,
   input  logic                  rst_n,
   addsub_arbiter_if.slave       bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;     // requester granted most recently
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic        sub_q, sub_d;
   logic        id_q, id_d;
   logic [15:0] result_q, result_d;
   logic        cout_q, cout_d;
   logic        ovf_q, ovf_d;

   logic        w_gnt0;
   logic        w_gnt1;
   logic [15:0] w_sum;
   logic        w_cout;
   logic        w_ovf;

   adder_subtractor_16_bit u_addsub (
      .a_i    (a_q),
      .b_i    (b_q),
      .sub_i  (sub_q),
      .sum_o  (w_sum),
      .cout_o (w_cout),
      .ovf_o  (w_ovf)
   );

   // Next-state, grant and capture logic for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      id_d     = id_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      w_gnt0   = 1'b0;
      w_gnt1   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Grants are suppressed while reset is held, since state is
            // already forced to IDLE asynchronously.
            if (rst_n) begin
               // On a tie, requester 0 wins only if 1 was granted last.
               if (bus.req0 && (!bus.req1 || last_q)) begin
                  w_gnt0 = 1'b1;
               end else if (bus.req1) begin
                  w_gnt1 = 1'b1;
               end
            end
            if (w_gnt0 || w_gnt1) begin
               id_d    = w_gnt1;
               last_d  = w_gnt1;
               a_d     = w_gnt1 ? bus.a1   : bus.a0;
               b_d     = w_gnt1 ? bus.b1   : bus.b0;
               sub_d   = w_gnt1 ? bus.sub1 : bus.sub0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = w_sum;
            cout_d   = w_cout;
            ovf_d    = w_ovf;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, operand and result registers; pointer resets to 1 so
   // requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         last_q   <= 1'b1;
         a_q      <= 16'd0;
         b_q      <= 16'd0;
         sub_q    <= 1'b0;
         id_q     <= 1'b0;
         result_q <= 16'd0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         id_q     <= id_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.gnt0      = w_gnt0;
   assign bus.gnt1      = w_gnt1;
   assign bus.res_valid = (state_q == S_RESP);
   assign bus.res_id    = id_q;
   assign bus.result    = result_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_addsub_arbiter                                     |
// | Purpose  : Directed and light random checks of addsub_arbiter.   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_addsub_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   addsub_arbiter_if bus ();

   addsub_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Safety net in case the sequence stalls.
   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic no_gnt(input string tag);
      check({tag, "_gnt0"}, {31'd0, bus.gnt0}, 32'd0);
      check({tag, "_gnt1"}, {31'd0, bus.gnt1}, 32'd0);
   endtask

   // One transaction starting in an IDLE cycle with inputs already set.
   task automatic txn(input logic exp_id, input logic [15:0] er, input logic ec,
                      input logic eo, input bit rnd_ready);
      int  n;
      bit  done;
      @(negedge clk);
      check("gnt0", {31'd0, bus.gnt0}, {31'd0, !exp_id});
      check("gnt1", {31'd0, bus.gnt1}, {31'd0, exp_id});
      check("valid_idle", {31'd0, bus.res_valid}, 32'd0);
      next_cycle();
      @(negedge clk);
      no_gnt("exec");
      check("valid_exec", {31'd0, bus.res_valid}, 32'd0);
      next_cycle();
      n    = 0;
      done = 1'b0;
      while (!done) begin
         bus.res_ready = (rnd_ready && n < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         check("valid_resp", {31'd0, bus.res_valid}, 32'd1);
         check("result", {16'd0, bus.result}, {16'd0, er});
         check("cout", {31'd0, bus.cout}, {31'd0, ec});
         check("ovf", {31'd0, bus.ovf}, {31'd0, eo});
         check("res_id", {31'd0, bus.res_id}, {31'd0, exp_id});
         no_gnt("resp");
         done = bus.res_ready;
         n++;
         next_cycle();
      end
      bus.res_ready = 1'b1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd0);
      check({tag, "_result"}, {16'd0, bus.result}, 32'd0);
      check({tag, "_cout"}, {31'd0, bus.cout}, 32'd0);
      check({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
      check({tag, "_id"}, {31'd0, bus.res_id}, 32'd0);
      no_gnt(tag);
   endtask

   initial begin
      logic        mlast;
      logic [1:0]  pat;
      logic        eid;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      logic [15:0] beff;
      logic [16:0] s17;

      rst_n         = 1'b0;
      bus.req0      = 1'b1;   // held high during reset: must not be granted
      bus.req1      = 1'b0;
      bus.a0        = 16'd0;
      bus.b0        = 16'd0;
      bus.a1        = 16'd0;
      bus.b1        = 16'd0;
      bus.sub0      = 1'b0;
      bus.sub1      = 1'b0;
      bus.res_ready = 1'b1;

      // Reset state
      @(negedge clk);
      check_zero_outputs("reset");
      next_cycle();
      rst_n = 1'b1;

      // 23 + 3
      bus.a0 = 16'd23; bus.b0 = 16'd3; bus.sub0 = 1'b0;
      txn(1'b0, 16'd26, 1'b0, 1'b0, 1'b0);

      // Fresh reset, then both requesters held: grants alternate 0,1,0,1
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      bus.req0 = 1'b1; bus.a0 = 16'd23; bus.b0 = 16'd3;  bus.sub0 = 1'b1;
      bus.req1 = 1'b1; bus.a1 = 16'd21; bus.b1 = 16'd75; bus.sub1 = 1'b1;
      txn(1'b0, 16'd20,     1'b1, 1'b0, 1'b0);
      txn(1'b1, 16'hFFCA,   1'b0, 1'b0, 1'b0);
      txn(1'b0, 16'd20,     1'b1, 1'b0, 1'b0);
      txn(1'b1, 16'hFFCA,   1'b0, 1'b0, 1'b0);

      // Signed overflow on add, and the matching subtraction
      bus.req0 = 1'b0;
      bus.a1 = 16'd16800; bus.b1 = 16'd16900; bus.sub1 = 1'b0;
      txn(1'b1, 16'h83A4, 1'b0, 1'b1, 1'b0);
      bus.sub1 = 1'b1;
      txn(1'b1, 16'hFF9C, 1'b0, 1'b0, 1'b0);

      // Back-pressure: res_ready low 4 cycles in RESP with both requesting
      bus.req0 = 1'b1; bus.a0 = 16'd100; bus.b0 = 16'd1; bus.sub0 = 1'b1;
      bus.req1 = 1'b1; bus.a1 = 16'd5;   bus.b1 = 16'd7; bus.sub1 = 1'b0;
      bus.res_ready = 1'b0;
      @(negedge clk);
      check("bp_gnt0", {31'd0, bus.gnt0}, 32'd1);
      check("bp_gnt1", {31'd0, bus.gnt1}, 32'd0);
      next_cycle();
      @(negedge clk);
      no_gnt("bp_exec");
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_valid", {31'd0, bus.res_valid}, 32'd1);
         check("bp_result", {16'd0, bus.result}, 32'd99);
         check("bp_cout", {31'd0, bus.cout}, 32'd1);
         check("bp_id", {31'd0, bus.res_id}, 32'd0);
         no_gnt("bp_hold");
         next_cycle();
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_last", {31'd0, bus.res_valid}, 32'd1);
      check("bp_result_last", {16'd0, bus.result}, 32'd99);
      next_cycle();
      txn(1'b1, 16'd12, 1'b0, 1'b0, 1'b0);

      // Reset during RESP
      bus.req1 = 1'b0;
      bus.a0 = 16'd1000; bus.b0 = 16'd1; bus.sub0 = 1'b0;
      bus.res_ready = 1'b0;
      @(negedge clk);
      check("rr_gnt0", {31'd0, bus.gnt0}, 32'd1);
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("rr_valid", {31'd0, bus.res_valid}, 32'd1);
      check("rr_result", {16'd0, bus.result}, 32'd1001);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("rst_resp");
      next_cycle();
      rst_n = 1'b1;
      bus.req0 = 1'b0;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rr_no_valid", {31'd0, bus.res_valid}, 32'd0);
         next_cycle();
      end
      // Pointer was 0 before reset; tie must now go to requester 0
      bus.req0 = 1'b1; bus.a0 = 16'd7; bus.b0 = 16'd2; bus.sub0 = 1'b1;
      bus.req1 = 1'b1; bus.a1 = 16'd3; bus.b1 = 16'd4; bus.sub1 = 1'b0;
      txn(1'b0, 16'd5, 1'b1, 1'b0, 1'b0);

      // Reset during EXEC (requester 1 granted by the tie)
      @(negedge clk);
      check("re_gnt1", {31'd0, bus.gnt1}, 32'd1);
      next_cycle();
      rst_n = 1'b0;
      #1;
      check_zero_outputs("rst_exec");
      next_cycle();
      rst_n = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("re_no_valid", {31'd0, bus.res_valid}, 32'd0);
         next_cycle();
      end
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      txn(1'b0, 16'd5, 1'b1, 1'b0, 1'b0);

      // Random traffic against a 17-bit reference, random res_ready
      mlast = 1'b0;
      for (int t = 0; t < 16; t++) begin
         pat = 2'($urandom_range(1, 3));
         bus.req0 = pat[0];
         bus.req1 = pat[1];
         bus.a0 = 16'($urandom); bus.b0 = 16'($urandom); bus.sub0 = 1'($urandom_range(0, 1));
         bus.a1 = 16'($urandom); bus.b1 = 16'($urandom); bus.sub1 = 1'($urandom_range(0, 1));
         eid  = (pat == 2'b11) ? !mlast : pat[1];
         ra   = eid ? bus.a1 : bus.a0;
         rb   = eid ? bus.b1 : bus.b0;
         rs   = eid ? bus.sub1 : bus.sub0;
         beff = rs ? ~rb : rb;
         s17  = {1'b0, ra} + {1'b0, beff} + {16'd0, rs};
         txn(eid, s17[15:0], s17[16],
             (ra[15] == beff[15]) && (s17[15] != ra[15]), 1'b1);
         mlast = eid;
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL expose clk input 1: single clock; all state updates on rising edge.
REQ-002 SHALL expose rst_n input 1: asynchronous, active-low reset.
REQ-003 SHALL expose req0, req1 input 1 each: requester k has an operation pending.
REQ-004 SHALL expose a0, b0, a1, b1 input 16 each: operands of requester k.
REQ-005 SHALL expose sub0, sub1 input 1 each: 1 = a-b, 0 = a+b for requester k.
REQ-006 SHALL expose gnt0, gnt1 output 1 each: operands of requester k accepted this cycle.
REQ-007 SHALL expose res_valid output 1, res_ready input 1: result channel handshake.
REQ-008 SHALL expose res_id output 1: requester that owns the current result.
REQ-009 SHALL expose result output 16, cout output 1, ovf output 1: sum/difference, carry-out, signed overflow.

Function
REQ-010 SHALL contain exactly one instance of adder_subtractor_16_bit, shared by both requesters, with the registered operands and op bit as its inputs.
REQ-011 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-012 IDLE: if req0|req1, SHALL assert exactly one gnt (combinationally, same cycle), capture that requester's a, b, sub and id on the clock edge, and go to EXEC; otherwise remain in IDLE with both gnt low.
REQ-013 Arbitration SHALL be round-robin: single request -> grant it; both -> grant the requester not granted last; the last-grant pointer updates only on a grant.
REQ-014 EXEC (one cycle): SHALL register result, cout, ovf from the adder/subtractor and go to RESP.
REQ-015 RESP: SHALL hold res_valid=1 with result, cout, ovf, res_id stable until res_ready=1 is sampled; on that edge SHALL go to IDLE with res_valid=0.
REQ-016 Latency SHALL be: gnt in cycle T, res_valid high from cycle T+2; with res_ready held high, the next gnt is earliest in cycle T+3.
REQ-017 gnt0/gnt1 SHALL be 0 in EXEC and RESP regardless of req; requests are not queued, requesters hold req and operands until granted.
REQ-018 Arithmetic SHALL be 16-bit modulo: result = (a + (b XOR {16{sub}}) + sub) mod 2^16; cout = bit 16 of that sum (for subtraction, cout=1 means no borrow).
REQ-019 ovf SHALL be 1 when a[15] equals effective-b[15] and result[15] differs from a[15].
REQ-020 res_ready high outside RESP SHALL be ignored.
REQ-021 A requester whose req is still high after its grant SHALL be treated as a new request in the next IDLE, subject to REQ-013.

Reset
REQ-022 rst_n=0 SHALL immediately (without a clock) force state IDLE, res_valid=0, result=0, cout=0, ovf=0, res_id=0, and the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-023 Reset in EXEC or RESP SHALL discard the in-flight operation; no res_valid SHALL follow for it after rst_n rises.
REQ-024 While rst_n=0, gnt0 and gnt1 SHALL be 0.

Verification
REQ-025 req0=1, a0=23, b0=3, sub0=0 -> gnt0 in cycle T; res_valid in T+2 with result=26, cout=0, ovf=0, res_id=0.
REQ-026 After reset, req0 and req1 both held high (req0: 23-3; req1: 21-75, sub=1) -> first result res_id=0, result=20, cout=1; second result res_id=1, result=0xFFCA, cout=0, ovf=0; then grants alternate 0,1,0,1.
REQ-027 req1: 16800+16900 -> result=0x83A4, cout=0, ovf=1; req1: 16800-16900 -> result=0xFF9C, cout=0, ovf=0.
REQ-028 res_ready held low 4 cycles in RESP with req0 and req1 high -> res_valid and outputs stable, no gnt; the result is consumed on the first cycle res_ready=1, IDLE and a new gnt follow in the next cycle.
REQ-029 rst_n pulsed low during RESP (and separately during EXEC) -> outputs zero immediately; no res_valid for the aborted op; the next tie is granted to requester 0.
REQ-030 Randomized add/sub on both ports with random res_ready -> every result matches a 17-bit reference model, no gnt outside IDLE, at most one gnt per cycle.
